// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Pipeline stage register for the IF/ID, ID/EXE, EXE/MEM and MEM/WB
//   boundaries. Moves a packed payload plus an exception vector across the
//   boundary with a valid/ready handshake. Supports synchronous flush and
//   keeps a saturating count of back-pressure cycles.
//
//   Build option: define PIPE_SKID_EN to get a 2-entry skid buffer whose
//   in_ready is a flop output. Without it the stage is a single register
//   and in_ready is combinational from out_ready.
//
// Ports
//   clk          clock, all state changes on posedge
//   rst          synchronous reset, active-low
//   flush        kill stage contents (redirect / exception commit)
//   in_valid     upstream offers an instruction
//   in_ready     stage accepts this cycle
//   in_data      upstream payload (WIDTH)
//   in_exc       upstream exception flags (EXC_W)
//   out_valid    out_data/out_exc hold a valid instruction
//   out_ready    downstream accepts this cycle
//   out_data     registered payload (WIDTH)
//   out_exc      registered exception flags (EXC_W)
//   out_has_exc  registered OR of out_exc, 0 while out_valid is 0
//   stall_cnt    saturating count of cycles with out_valid && !out_ready
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter int               EXC_W     = 9,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [EXC_W-1:0] in_exc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [EXC_W-1:0] out_exc,
  output logic             out_has_exc,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_MAIN      = 2'd1,
    ST_MAIN_SKID = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             in_xfer;
  logic             out_xfer;
  logic             main_ld_in;
  logic             main_clr;

  logic [WIDTH-1:0] main_data_p0;
  logic [EXC_W-1:0] main_exc_p0;
  logic             main_has_exc_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign out_valid   = (state_q != ST_EMPTY);
  assign out_data    = main_data_p0;
  assign out_exc     = main_exc_p0;
  assign out_has_exc = main_has_exc_p0;

  // An input offered during flush is dropped even when in_ready is high.
  assign in_xfer  = in_valid && in_ready && !flush;
  assign out_xfer = out_valid && out_ready;

`ifdef PIPE_SKID_EN
  logic             main_ld_skid;
  logic             skid_ld;
  logic             ready_q;
  logic [WIDTH-1:0] skid_data_p0;
  logic [EXC_W-1:0] skid_exc_p0;

  // Registered ready: low exactly while the skid entry is occupied.
  assign in_ready = ready_q;
`else
  // Single register: free slot, or the current occupant leaves this cycle.
  assign in_ready = (state_q == ST_EMPTY) || out_ready;
`endif

  always_comb begin
    state_d    = state_q;
    main_ld_in = 1'b0;
    main_clr   = 1'b0;
`ifdef PIPE_SKID_EN
    main_ld_skid = 1'b0;
    skid_ld      = 1'b0;
`endif
    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d    = ST_MAIN;
            main_ld_in = 1'b1;
          end
        end
        ST_MAIN: begin
          if (in_xfer && out_xfer) begin
            main_ld_in = 1'b1;
          end else if (out_xfer) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
          end
`ifdef PIPE_SKID_EN
          else if (in_xfer) begin
            state_d = ST_MAIN_SKID;
            skid_ld = 1'b1;
          end
`endif
        end
`ifdef PIPE_SKID_EN
        ST_MAIN_SKID: begin
          if (out_xfer) begin
            state_d      = ST_MAIN;
            main_ld_skid = 1'b1;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage register: main entry driving out_*
  always_ff @(posedge clk) begin
    if (!rst) begin
      main_data_p0    <= RESET_VAL;
      main_exc_p0     <= '0;
      main_has_exc_p0 <= 1'b0;
    end else if (main_ld_in) begin
      main_data_p0    <= in_data;
      main_exc_p0     <= in_exc;
      main_has_exc_p0 <= |in_exc;
    end
`ifdef PIPE_SKID_EN
    else if (main_ld_skid) begin
      main_data_p0    <= skid_data_p0;
      main_exc_p0     <= skid_exc_p0;
      main_has_exc_p0 <= |skid_exc_p0;
    end
`endif
    else if (main_clr) begin
      // Payload is left in place; only the exception view is cleared.
      main_exc_p0     <= '0;
      main_has_exc_p0 <= 1'b0;
    end
  end

`ifdef PIPE_SKID_EN
  // Skid entry: captures the input accepted while the main entry is stalled
  always_ff @(posedge clk) begin
    if (skid_ld) begin
      skid_data_p0 <= in_data;
      skid_exc_p0  <= in_exc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= (state_d != ST_MAIN_SKID);
    end
  end
`endif

  // Back-pressure counter: not cleared by flush
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Directed bench for pipe_stage_reg. Uses CNT_W=4 so counter saturation is
//   reachable quickly, and a non-zero RESET_VAL so the reset payload is
//   distinguishable from zero. Expectations adapt to PIPE_SKID_EN.
module tb_pipe_stage_reg;

  localparam int          WIDTH = 32;
  localparam int          EXC_W = 9;
  localparam int          CNT_W = 4;
  localparam logic [31:0] RVAL  = 32'hDEAD_BEEF;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [EXC_W-1:0] in_exc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [EXC_W-1:0] out_exc;
  logic             out_has_exc;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(
    .WIDTH    (WIDTH),
    .EXC_W    (EXC_W),
    .RESET_VAL(RVAL),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_exc     (in_exc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_exc    (out_exc),
    .out_has_exc(out_has_exc),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_exc    = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    in_exc    = 9'h1FF;
    out_ready = 1'b1;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== RVAL) begin errors++; $display("FAIL reset_out_data got %h want %h", out_data, RVAL); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    checks++; if (out_has_exc !== 1'b0) begin errors++; $display("FAIL reset_has_exc got %0b want 0", out_has_exc); end
    checks++; if (out_exc !== 9'h0) begin errors++; $display("FAIL reset_out_exc got %h want 0", out_exc); end
    rst      = 1'b1;
    in_valid = 1'b0;
    in_exc   = '0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_streaming();
    logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vals[i];
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %0b want 1", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin
        errors++; $display("FAIL stream_out[%0d] got v=%0b d=%h want v=1 d=%h", i, out_valid, out_data, vals[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_back_pressure();
    logic [31:0] items [4] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    bit          rdy [10]  = '{1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    logic [31:0] exp_q [$];
    logic [31:0] od;
    logic [31:0] ev;
    int          idx;
    int          n_out;
    bit          acc;
    bit          osent;
    bit          want_rdy;
    idx   = 0;
    n_out = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      out_ready = rdy[i];
      in_valid  = (idx < 4);
      in_data   = (idx < 4) ? items[idx] : 32'h0;
      #1;
      acc   = in_valid && in_ready;
      osent = out_valid && out_ready;
      od    = out_data;
      if (i >= 1 && i <= 4) begin
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hA1) begin
          errors++; $display("FAIL bp_hold[%0d] got v=%0b d=%h want v=1 d=a1", i, out_valid, out_data);
        end
`ifdef PIPE_SKID_EN
        want_rdy = (i == 1);
`else
        want_rdy = 1'b0;
`endif
        checks++; if (in_ready !== want_rdy) begin
          errors++; $display("FAIL bp_in_ready[%0d] got %0b want %0b", i, in_ready, want_rdy);
        end
      end
      tick();
      if (acc) begin
        exp_q.push_back(items[idx]);
        idx++;
      end
      if (osent) begin
        n_out++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_order spurious output %h want none", od);
        end else begin
          ev = exp_q.pop_front();
          if (od !== ev) begin errors++; $display("FAIL bp_order got %h want %h", od, ev); end
        end
      end
    end
    in_valid = 1'b0;
    checks++; if (stall_cnt !== 4'd4) begin errors++; $display("FAIL bp_stall_cnt got %0d want 4", stall_cnt); end
    checks++; if (n_out !== 4 || idx !== 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_count got out=%0d in=%0d left=%0d want 4 4 0", n_out, idx, exp_q.size());
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hB1;
    in_exc    = 9'h004;
    tick();
`ifdef PIPE_SKID_EN
    in_data = 32'hB2;
    in_exc  = 9'h000;
`else
    in_valid = 1'b0;
`endif
    tick();
    checks++; if (out_has_exc !== 1'b1) begin errors++; $display("FAIL flush_pre_has_exc got %0b want 1", out_has_exc); end
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hBF;
    in_exc    = 9'h1FF;
    out_ready = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    in_exc   = '0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %0b want 0", out_valid); end
    checks++; if (out_has_exc !== 1'b0) begin errors++; $display("FAIL flush_has_exc got %0b want 0", out_has_exc); end
    checks++; if (out_exc !== 9'h0) begin errors++; $display("FAIL flush_out_exc got %h want 0", out_exc); end
    checks++; if (out_data !== 32'hB1) begin errors++; $display("FAIL flush_out_data got %h want b1", out_data); end
    checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL flush_stall_cnt got %0d want 1", stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0b want 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_leak[%0d] got v=1 d=%h want v=0", i, out_data);
      end
    end
  endtask

  task automatic test_exceptions();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hC1;
    in_exc    = 9'b000100000;
    tick();
    checks++; if (out_has_exc !== 1'b1) begin errors++; $display("FAIL exc_set got %0b want 1", out_has_exc); end
    checks++; if (out_exc !== 9'b000100000) begin errors++; $display("FAIL exc_vec got %h want 020", out_exc); end
    in_data = 32'hC2;
    in_exc  = 9'h0;
    tick();
    checks++; if (out_has_exc !== 1'b0 || out_data !== 32'hC2) begin
      errors++; $display("FAIL exc_clear got h=%0b d=%h want h=0 d=c2", out_has_exc, out_data);
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || out_has_exc !== 1'b0) begin
      errors++; $display("FAIL exc_idle got v=%0b h=%0b want 0 0", out_valid, out_has_exc);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hD1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (14) tick();
    checks++; if (stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_14 got %0d want 14", stall_cnt); end
    tick();
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_15 got %0d want 15", stall_cnt); end
    repeat (5) tick();
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", stall_cnt); end
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hD1) begin
      errors++; $display("FAIL sat_payload got v=%0b d=%h want v=1 d=d1", out_valid, out_data);
    end
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_exc    = '0;
    out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_exceptions();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
